pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 255, consecutive-stall-cycle count that raises timeout_o (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_if  input  1  fetch not ready (instruction memory wait).
REQ-005 stallreq_id  input  1  decode hazard (load-use, operand not forwardable).
REQ-006 stallreq_ex  input  1  execute busy (multi-cycle op).
REQ-007 stallreq_mem  input  1  data memory wait.
REQ-008 flush_req  input  1  exception/redirect raised in mem stage.
REQ-009 flush_pc_i  input  32 (InstAddrBus)  redirect target, valid with flush_req.
REQ-010 stall_o  output  6 (StallBus)  hold bits {wb,mem,ex,id,if,pc}, bit0 = pc.
REQ-011 flush_o  output  1  clear all pipeline registers and load new_pc_o into pc.
REQ-012 new_pc_o  output  32  redirect target, valid while flush_o=1.
REQ-013 timeout_o  output  1  one-cycle pulse, stall exceeded STALL_LIMIT.
REQ-014 stall_cnt_o  output  32  total stalled cycles since reset, wraps.

Function
REQ-015 Three-state FSM: RUN, FLUSH, RECOVER.
REQ-016 RUN: stall_o combinational from requests, fixed priority mem > ex > id > if.
REQ-017 Encodings: mem 6'b011111; ex 6'b001111; id 6'b000111; if 6'b000111; none 6'b000000.
REQ-018 RUN with flush_req=1: latch flush_pc_i, next state FLUSH; stall_o forced 6'b000000 that cycle regardless of stall requests.
REQ-019 FLUSH (exactly one cycle): flush_o=1 (registered), new_pc_o=latched pc, stall_o=0; next state RECOVER.
REQ-020 RECOVER (exactly one cycle): flush_o=0, stall_o=0, all stall requests ignored (they belong to flushed instructions); next state RUN.
REQ-021 flush_req during FLUSH or RECOVER is ignored; latched pc not overwritten.
REQ-022 Simultaneous flush_req and any stallreq in RUN: flush wins (REQ-018).
REQ-023 new_pc_o holds last latched value outside FLUSH; 0 after reset.
REQ-024 stall_cnt_o increments by 1 each cycle stall_o != 0; 32'hFFFFFFFF wraps to 0.
REQ-025 Watchdog counter (8-bit) increments each cycle stall_o != 0, clears on any cycle stall_o == 0 or state != RUN.
REQ-026 When watchdog counter equals STALL_LIMIT-1 and stall_o != 0: timeout_o=1 next cycle for one cycle, counter returns to 0, counting resumes if stall persists.
REQ-027 timeout_o is informational; stall_o unaffected.

Reset
REQ-028 rst=1 at rising edge: state RUN, flush_o=0, new_pc_o=0, latched pc=0, timeout_o=0, stall_cnt_o=0, watchdog=0.
REQ-029 While rst=1, stall_o=6'b000000 combinationally; requests ignored.
REQ-030 rst asserted in FLUSH or RECOVER aborts sequence; first post-reset cycle is RUN with flush_o=0.

Structure
REQ-031 defines.v holds StallBus (5:0), the four stall encodings, state encodings PIPE_RUN/PIPE_FLUSH/PIPE_RECOVER, and NoStall.
REQ-032 One sub-module, stall_watchdog: 8-bit counter plus timeout pulse, parameter STALL_LIMIT; FSM, priority encoder, perf counter stay in pipe_ctrl.

Verification
REQ-033 stallreq_id=1 and stallreq_mem=1 same cycle in RUN -> stall_o=6'b011111 that cycle; stall_cnt_o +1.
REQ-034 flush_req=1, flush_pc_i=32'h0000_0100, stallreq_ex=1 -> stall_o=0 that cycle; next cycle flush_o=1, new_pc_o=32'h100; following cycle flush_o=0, stall_o=0 though stallreq_ex=1; then stall_o=6'b001111.
REQ-035 STALL_LIMIT=4, stallreq_ex held 10 cycles -> timeout_o pulses on cycles 5 and 9 after first stall cycle, single-cycle each.
REQ-036 Preload/force stall_cnt_o to 32'hFFFFFFFE, two stall cycles -> 32'hFFFFFFFF then 32'h0.
REQ-037 rst=1 during FLUSH -> next cycle flush_o=0, new_pc_o=0, state RUN; flush_req in RECOVER with flush_pc_i=32'h200 -> no second flush_o pulse, new_pc_o unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control block: stall bus
// layout, per-stage stall encodings, FSM states and the priority encoder.
package pipe_ctrl_pkg;

  localparam int unsigned StallBusWidth = 6;
  localparam int unsigned InstAddrWidth = 32;
  localparam int unsigned WdWidth       = 8;

  typedef logic [StallBusWidth-1:0] stall_bus_t;
  typedef logic [InstAddrWidth-1:0] inst_addr_t;

  // Hold bits {wb, mem, ex, id, if, pc}; bit 0 is the pc.
  localparam stall_bus_t NoStall  = 6'b000000;
  localparam stall_bus_t StallIf  = 6'b000111;
  localparam stall_bus_t StallId  = 6'b000111;
  localparam stall_bus_t StallEx  = 6'b001111;
  localparam stall_bus_t StallMem = 6'b011111;

  typedef enum logic [1:0] {
    PIPE_RUN     = 2'd0,
    PIPE_FLUSH   = 2'd1,
    PIPE_RECOVER = 2'd2
  } pipe_state_e;

  // Fixed priority: the deepest stalled stage decides how much of the
  // pipe in front of it must hold.
  function automatic stall_bus_t stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    stall_bus_t enc;
    if (req_mem) begin
      enc = StallMem;
    end else if (req_ex) begin
      enc = StallEx;
    end else if (req_id) begin
      enc = StallId;
    end else if (req_if) begin
      enc = StallIf;
    end else begin
      enc = NoStall;
    end
    return enc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Stall watchdog: counts consecutive stalled RUN cycles and emits a
// one-cycle timeout pulse each time STALL_LIMIT of them have elapsed.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active_i,
  input  logic in_run_i,
  output logic timeout_o
);

  localparam logic [WdWidth-1:0] LimitLast = WdWidth'(STALL_LIMIT - 1);

  logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;

  // Next-state: count while stalled in RUN, wrap to 0 on the terminal count.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
    if (stall_active_i && in_run_i) begin
      if (wd_cnt_q == LimitLast) begin
        wd_cnt_d  = '0;
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges per-stage stall requests into a hold vector,
// sequences redirect flushes (RUN -> FLUSH -> RECOVER) and keeps a
// total-stall performance counter plus a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stallreq_if,
  input  logic                     stallreq_id,
  input  logic                     stallreq_ex,
  input  logic                     stallreq_mem,
  input  logic                     flush_req,
  input  logic [InstAddrWidth-1:0] flush_pc_i,
  output logic [StallBusWidth-1:0] stall_o,
  output logic                     flush_o,
  output logic [InstAddrWidth-1:0] new_pc_o,
  output logic                     timeout_o,
  output logic [31:0]              stall_cnt_o
);

  pipe_state_e state_q, state_d;
  inst_addr_t  pc_latch_q, pc_latch_d;
  logic        flush_q, flush_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  stall_bus_t  req_stall;
  logic        stall_active;

  // Priority-encode the raw stage requests.
  always_comb begin
    req_stall = stall_encode(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
  end

  // FSM next-state and stall output; stalls only pass through in RUN
  // without a concurrent flush, and never while reset is asserted.
  always_comb begin
    state_d    = state_q;
    pc_latch_d = pc_latch_q;
    flush_d    = 1'b0;
    stall_o    = NoStall;
    unique case (state_q)
      PIPE_RUN: begin
        if (flush_req) begin
          pc_latch_d = flush_pc_i;
          flush_d    = 1'b1;
          state_d    = PIPE_FLUSH;
        end else begin
          stall_o = req_stall;
        end
      end
      PIPE_FLUSH: begin
        state_d = PIPE_RECOVER;
      end
      PIPE_RECOVER: begin
        // Requests this cycle come from flushed instructions.
        state_d = PIPE_RUN;
      end
      default: begin
        state_d = PIPE_RUN;
      end
    endcase
    if (rst) begin
      stall_o = NoStall;
    end
  end

  assign stall_active = (stall_o != NoStall);

  // Performance counter next-state; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_active) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State, redirect target, flush pulse and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PIPE_RUN;
      pc_latch_q  <= '0;
      flush_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_latch_q  <= pc_latch_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_o     = flush_q;
  assign new_pc_o    = pc_latch_q;
  assign stall_cnt_o = stall_cnt_q;

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_active_i(stall_active),
    .in_run_i      (state_q == PIPE_RUN),
    .timeout_o     (timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a cycle-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STALL_LIMIT(Limit)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (req_if),
    .stallreq_id (req_id),
    .stallreq_ex (req_ex),
    .stallreq_mem(req_mem),
    .flush_req   (flush_req),
    .flush_pc_i  (flush_pc),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .new_pc_o    (new_pc_o),
    .timeout_o   (timeout_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic        model_ok = 1'b0;
  logic        preload  = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_pc  = '0;
  logic        m_flush = 1'b0;
  logic        m_timeout = 1'b0;
  int          m_quiet = 0;   // cycles left in the post-redirect window
  int          m_streak = 0;  // consecutive stalled cycles since last pulse

  function automatic logic [5:0] m_stall();
    if (rst || m_quiet != 0 || flush_req) return 6'b000000;
    if (req_mem) return 6'b011111;
    if (req_ex)  return 6'b001111;
    if (req_id)  return 6'b000111;
    if (req_if)  return 6'b000111;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin : model_update
    logic [5:0] s;
    int         st;
    if (rst) begin
      model_ok  <= 1'b1;
      m_cnt     <= '0;
      m_pc      <= '0;
      m_flush   <= 1'b0;
      m_timeout <= 1'b0;
      m_quiet   <= 0;
      m_streak  <= 0;
    end else begin
      s = m_stall();
      if (preload) m_cnt <= 32'hFFFF_FFFE;
      else if (s != 0) m_cnt <= m_cnt + 32'd1;
      if (s != 0) begin
        st = m_streak + 1;
        if (st == int'(Limit)) begin
          m_timeout <= 1'b1;
          m_streak  <= 0;
        end else begin
          m_timeout <= 1'b0;
          m_streak  <= st;
        end
      end else begin
        m_timeout <= 1'b0;
        m_streak  <= 0;
      end
      if (m_quiet > 0) begin
        m_quiet <= m_quiet - 1;
        m_flush <= 1'b0;
      end else if (flush_req) begin
        m_pc    <= flush_pc;
        m_quiet <= 2;
        m_flush <= 1'b1;
      end else begin
        m_flush <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_stall", 32'(stall_o), 32'(m_stall()));
      check("model_flush", 32'(flush_o), 32'(m_flush));
      check("model_new_pc", new_pc_o, m_pc);
      check("model_timeout", 32'(timeout_o), 32'(m_timeout));
      if (!preload) check("model_stall_cnt", stall_cnt_o, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mem, input logic ex, input logic id, input logic fi,
                       input logic fl, input logic [31:0] pc);
    req_mem   = mem;
    req_ex    = ex;
    req_id    = id;
    req_if    = fi;
    flush_req = fl;
    flush_pc  = pc;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    // Requests are ignored while reset is held.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_new_pc", new_pc_o, 32'h0);
    check("rst_cnt", stall_cnt_o, 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'h0);
    step();
    rst = 1'b0;

    // Single requests, then id+mem together.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); check("enc_if", 32'(stall_o), 32'h07); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("enc_id", 32'(stall_o), 32'h07); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("enc_ex", 32'(stall_o), 32'h0F); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("enc_mem", 32'(stall_o), 32'h1F); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("id_mem_prio", 32'(stall_o), 32'h1F);
    check("cnt_before", stall_cnt_o, 32'd4);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("enc_none", 32'(stall_o), 32'h0);
    check("cnt_after", stall_cnt_o, 32'd5);
    step();

    // Flush beats a concurrent execute stall.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    @(negedge clk); check("flush_cycle_stall", 32'(stall_o), 32'h0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("flush_pulse", 32'(flush_o), 32'h1);
    check("flush_new_pc", new_pc_o, 32'h100);
    check("flush_state_stall", 32'(stall_o), 32'h0);
    step();
    @(negedge clk);
    check("recover_flush", 32'(flush_o), 32'h0);
    check("recover_stall", 32'(stall_o), 32'h0);
    step();
    @(negedge clk); check("post_recover_stall", 32'(stall_o), 32'h0F); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // Watchdog: ex held 10 cycles; pulses on stall cycles 5 and 9.
    for (int k = 1; k <= 12; k++) begin
      req_ex = (k <= 10);
      @(negedge clk);
      check($sformatf("timeout_k%0d", k), 32'(timeout_o), 32'((k == 5) || (k == 9)));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // Counter wrap: preload during an idle cycle, then two stall cycles.
    preload = 1'b1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    step();
    release dut.stall_cnt_q;
    preload = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("wrap_preload", stall_cnt_o, 32'hFFFF_FFFE); step();
    @(negedge clk); check("wrap_max", stall_cnt_o, 32'hFFFF_FFFF); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); check("wrap_zero", stall_cnt_o, 32'h0); step();

    // Reset during FLUSH aborts the sequence.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk); check("abort_in_flush", 32'(flush_o), 32'h1); step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_flush", 32'(flush_o), 32'h0);
    check("abort_new_pc", new_pc_o, 32'h0);
    step();

    // Redirects during FLUSH and RECOVER are ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_DEAD);
    @(negedge clk); check("ign_flush_pulse", 32'(flush_o), 32'h1); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    @(negedge clk); check("ign_recover_stall", 32'(stall_o), 32'h0); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("ign_no_second_flush", 32'(flush_o), 32'h0);
    check("ign_new_pc", new_pc_o, 32'h80);
    step();
    @(negedge clk);
    check("ign_still_no_flush", 32'(flush_o), 32'h0);
    check("ign_pc_held", new_pc_o, 32'h80);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
